// File: rtl/bcd_score_cnt.sv
// BCD up/down score counter: synchronised push-button inputs, clamped load,
// wrap or saturate at the limits, and leading-zero blanking for the display.
module bcd_score_cnt #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_cnt,
  input  logic                  inc_btn,
  input  logic                  dec_btn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  ovf,
  output logic                  unf,
  output logic                  zero,
  output logic [DIGITS-1:0]     blank
);

  localparam int W = 4 * DIGITS;

  logic [1:0] inc_sync;
  logic [1:0] dec_sync;
  logic       inc_hist;
  logic       dec_hist;
  logic       inc_edge;
  logic       dec_edge;

  // Everything resets to ones so a button already held high never looks like a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_sync <= 2'b11;
      dec_sync <= 2'b11;
      inc_hist <= 1'b1;
      dec_hist <= 1'b1;
    end else begin
      inc_sync <= {inc_sync[0], inc_btn};
      dec_sync <= {dec_sync[0], dec_btn};
      inc_hist <= inc_sync[1];
      dec_hist <= dec_sync[1];
    end
  end

  assign inc_edge = inc_sync[1] & ~inc_hist;
  assign dec_edge = dec_sync[1] & ~dec_hist;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] load_clamp;
  logic         carry;
  logic         borrow;
  logic         all_nines;
  logic         all_zeros;

  always_comb begin
    inc_val = cnt;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  always_comb begin
    dec_val = cnt;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (cnt[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    all_zeros = borrow;
  end

  // Non-BCD load nibbles are clamped so the count is always displayable.
  always_comb begin
    load_clamp = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clamp[4*i +: 4] = 4'd9;
      end else begin
        load_clamp[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  logic [W-1:0] cnt_next;
  logic         ovf_next;
  logic         unf_next;

  // Simultaneous inc and dec requests cancel each other out.
  always_comb begin
    cnt_next = cnt;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (clr_cnt) begin
      cnt_next = '0;
    end else if (load) begin
      cnt_next = load_clamp;
    end else if (inc_edge && dec_edge) begin
      cnt_next = cnt;
    end else if (inc_edge) begin
      if (all_nines) begin
        ovf_next = 1'b1;
        if (WRAP != 0) begin
          cnt_next = '0;
        end
      end else begin
        cnt_next = inc_val;
      end
    end else if (dec_edge) begin
      if (all_zeros) begin
        unf_next = 1'b1;
        if (WRAP != 0) begin
          cnt_next = dec_val;
        end
      end else begin
        cnt_next = dec_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      ovf <= ovf_next;
      unf <= unf_next;
    end
  end

  assign zero = ~|cnt;

  logic upper_zero;

  // Digit 0 is never blanked, so a zero count still shows a single 0.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (cnt[4*i +: 4] == 4'd0);
      blank[i]   = upper_zero;
    end
  end

endmodule
